// File: rtl/seq_gen_10010.sv
// Bit-serial pattern source: start -> first bit after the same edge, registered outputs, no backpressure.
// Optional err_inj input when SEQ_GEN_ERR_INJ_EN is defined (inverts the next driven pattern bit).
module seq_gen_10010 #(
  parameter int unsigned        PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
  parameter int unsigned        OVL_LEN = 2,
  parameter int unsigned        GAP     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       overlap,
  input  logic [7:0] rep_cnt,
  input  logic       stop,
`ifdef SEQ_GEN_ERR_INJ_EN
  input  logic       err_inj,
`endif
  output logic       data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    GAP_ST  = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  localparam logic [15:0] PAT16     = 16'(PATTERN);
  localparam logic [3:0]  FIRST_IDX = 4'(PAT_LEN - 1);
  localparam logic [3:0]  OVL_IDX   = 4'(PAT_LEN - 1 - OVL_LEN);
  localparam logic [7:0]  GAP_M1    = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rep_q, rep_d;
  logic [7:0] rep_cnt_q, rep_cnt_d;
  logic       ovl_q, ovl_d;
  logic       stop_q, stop_d;
  logic [7:0] gap_q, gap_d;
  logic       bit_d, vld_d, busy_d, done_d;
  logic       last_rep;
  logic [3:0] rep_start_idx;

  // Later repetitions skip the shared prefix only when they abut the previous one.
  assign rep_start_idx = (ovl_q && (GAP == 0)) ? OVL_IDX : FIRST_IDX;
  assign last_rep      = (rep_cnt_q != 8'd0) && ((rep_q + 8'd1) == rep_cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    rep_cnt_d = rep_cnt_q;
    ovl_d     = ovl_q;
    stop_d    = stop_q;
    gap_d     = gap_q;
    bit_d     = 1'b0;
    vld_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        rep_d  = 8'd0;
        stop_d = 1'b0;
        if (start) begin
          state_d   = SEND;
          rep_cnt_d = rep_cnt;
          ovl_d     = overlap;
          stop_d    = stop;
          idx_d     = FIRST_IDX;
          bit_d     = PAT16[FIRST_IDX];
          vld_d     = 1'b1;
          busy_d    = 1'b1;
        end
      end

      SEND: begin
        stop_d = stop_q | stop;
        if (idx_q != 4'd0) begin
          idx_d  = idx_q - 4'd1;
          bit_d  = PAT16[idx_q - 4'd1];
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else begin
          // Pattern boundary: the only place a burst may end.
          rep_d = rep_q + 8'd1;
          if (last_rep || stop_q || stop) begin
            state_d = DONE_ST;
            done_d  = 1'b1;
          end else if (GAP != 0) begin
            state_d = GAP_ST;
            gap_d   = GAP_M1;
            busy_d  = 1'b1;
          end else begin
            idx_d  = rep_start_idx;
            bit_d  = PAT16[rep_start_idx];
            vld_d  = 1'b1;
            busy_d = 1'b1;
          end
        end
      end

      GAP_ST: begin
        stop_d = stop_q | stop;
        busy_d = 1'b1;
        if (gap_q == 8'd0) begin
          state_d = SEND;
          idx_d   = FIRST_IDX;
          bit_d   = PAT16[FIRST_IDX];
          vld_d   = 1'b1;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      DONE_ST: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SEQ_GEN_ERR_INJ_EN
    if ((state_q == SEND) && err_inj && vld_d) begin
      bit_d = ~bit_d;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= 4'd0;
      rep_q      <= 8'd0;
      rep_cnt_q  <= 8'd0;
      ovl_q      <= 1'b0;
      stop_q     <= 1'b0;
      gap_q      <= 8'd0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      rep_cnt_q  <= rep_cnt_d;
      ovl_q      <= ovl_d;
      stop_q     <= stop_d;
      gap_q      <= gap_d;
      data_out   <= bit_d;
      data_valid <= vld_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: doc/seq_gen_10010.md
# seq_gen_10010

Bit-serial pattern generator: the transmit-side counterpart of the serial sequence detectors. On a start request it emits a fixed pattern (default 10010) MSB-first, repeated a programmable number of times. Consecutive repetitions are either full copies or share the pattern's self-overlapping prefix, and optional idle gaps can separate them. It sits in front of the detector blocks as a stimulus/line source and produces exact, countable match events in both overlapping and non-overlapping detection modes.

## Interface
Parameters:
- PAT_LEN, 5: pattern length in bits (2..16).
- PATTERN, 5'b10010: pattern, bit PAT_LEN-1 sent first.
- OVL_LEN, 2: bits shared between back-to-back repetitions in overlap mode. Must be < PAT_LEN. Must equal a true suffix/prefix overlap of PATTERN.
- GAP, 0: idle cycles inserted between repetitions (0..255).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a burst; sampled only in IDLE.
- overlap  in  1  latched at start. 1 = overlapping repetitions (only effective when GAP==0).
- rep_cnt  in  8  repetitions per burst, latched at start. 0 = continuous until stop.
- stop  in  1  end the burst at the next pattern boundary.
- data_out  out  1  serial bit; registered.
- data_valid  out  1  data_out carries a pattern bit this cycle.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- err_inj  in  1  present only with SEQ_GEN_ERR_INJ_EN.

## Operation
- FSM states and transitions:
  - IDLE: start=1 → SEND, and latch rep_cnt/overlap.
  - SEND: emit the pattern. After the last bit of a repetition, the next state is one of:
    - DONE_ST, if the burst is complete or stop was seen.
    - GAP_ST, if GAP>0.
    - SEND, otherwise.
  - GAP_ST: hold for GAP cycles, then → SEND.
  - DONE_ST: pulse done, then → IDLE.
- Bit index counter, 4 bits:
  - Starts at PAT_LEN-1 for the first repetition.
  - Starts at PAT_LEN-1-OVL_LEN for later repetitions when overlap=1 and GAP==0; these repetitions emit only the last PAT_LEN-OVL_LEN bits.
  - Otherwise starts at PAT_LEN-1 for every repetition.
- Repetition counter, 8 bits: incremented at each pattern end. The burst completes when it equals the latched rep_cnt (rep_cnt≠0). It wraps freely in continuous mode.
- stop:
  - Sticky once seen while busy. Checked only at pattern boundaries, so a pattern is never truncated.
  - stop in IDLE is ignored.
  - start and stop high together in IDLE: the burst starts, and exactly one repetition is sent.
- start while busy is ignored (not queued).
- Outside SEND, data_out=0 and data_valid=0.

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, done=0. FSM returns to IDLE and all counters clear.
- Reset mid-burst aborts immediately. No done pulse is generated.
- Start latency: start high at edge N → first bit and data_valid=1 after edge N. busy=1 from edge N.
- A single repetition occupies PAT_LEN consecutive valid cycles, or PAT_LEN-OVL_LEN for overlapped repetitions.
- Back-to-back repetitions (GAP=0) are contiguous, with no valid bubble.
- The cycle after the final bit: data_valid=0, done=1, busy=0. The next start is accepted in the cycle after done.
- stop is registered. If stop is asserted in the cycle the last bit of a pattern is on data_out, that pattern is the final one.

## Configuration
- SEQ_GEN_ERR_INJ_EN defined:
  - Adds input err_inj.
  - When err_inj=1 in a SEND cycle, the bit driven at the next edge is inverted. Only bits with data_valid=1 are affected.
  - Counters and FSM are unaffected.
- SEQ_GEN_ERR_INJ_EN undefined: the port is absent and output is always the pure pattern.

## Test plan
- Overlap burst: reset, start with rep_cnt=2, overlap=1, GAP=0 → data_out stream 1,0,0,1,0,0,1,0 (8 valid cycles). done pulses 1 cycle later. A downstream detector in overlapping mode reports 2 matches.
- Non-overlap burst: rep_cnt=3, overlap=0, GAP=2 → three 10010 groups, each separated by 2 cycles with data_valid=0. Total 19 cycles from first bit to done.
- Continuous mode with stop: rep_cnt=0. Assert stop at bit 2 of the 4th repetition → the 4th pattern completes fully. done follows. Exactly 4 patterns are emitted.
- Start while busy / stop in IDLE: start pulses during a burst are ignored (bit count unchanged). stop in IDLE leaves busy=0.
- Reset mid-burst: assert rst during the 2nd bit → all outputs 0 immediately, no done. A fresh start then yields a clean 10010.
- Error injection (macro defined): err_inj=1 during the cycle before the 3rd bit → stream 10110 for that repetition. Subsequent repetitions are unaffected.
